// File: rtl/mem_arbiter_rr_if.sv
// rtl/mem_arbiter_rr_if.sv - core-array and shared-RAM bus bundle for mem_arbiter_rr
//
// Groups the per-core request buses (packed, core i at [i*W +: W]) and the
// single RAM port.
//   slave  : the arbiter side (takes core requests and RAM read data, drives the rest)
//   master : the environment side (cores plus RAM)
interface mem_arbiter_rr_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CORE_NUM   = 4
);
  logic [CORE_NUM-1:0]            request;
  logic [CORE_NUM-1:0]            wren_core;
  logic [CORE_NUM*ADDR_WIDTH-1:0] address_in;
  logic [CORE_NUM*WIDTH-1:0]      data_in;
  logic [CORE_NUM*WIDTH-1:0]      data_out;
  logic [CORE_NUM-1:0]            response;
  logic [CORE_NUM-1:0]            grant;
  logic                           busy;
  logic [ADDR_WIDTH-1:0]          address;
  logic [WIDTH-1:0]               data_write;
  logic                           wren;
  logic [WIDTH-1:0]               data_read;

  modport slave (
    input  request, wren_core, address_in, data_in, data_read,
    output data_out, response, grant, busy, address, data_write, wren
  );

  modport master (
    output request, wren_core, address_in, data_in, data_read,
    input  data_out, response, grant, busy, address, data_write, wren
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - round-robin arbiter sharing one synchronous RAM port among cores
//
// Purpose: grants one core at a time access to a shared synchronous RAM. An
// access is IDLE (arbitrate) -> ACCESS (READ_LATENCY cycles) -> DONE (one
// cycle response pulse). Completion is purely latency-counted.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    mem_arbiter_rr_if.slave
//          request/wren_core/address_in/data_in  per-core inputs (packed)
//          data_out    per-core registered read data, held until next read
//          response    one-hot one-cycle completion pulse
//          grant       one-hot current owner, 0 when idle
//          busy        high in ACCESS and DONE
//          address/data_write/wren  RAM command, data_read  RAM read data
// All outputs are registered.
module mem_arbiter_rr #(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int CORE_NUM     = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_rr_if.slave bus
);

  localparam int IDX_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(READ_LATENCY - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(CORE_NUM - 1);
  localparam logic [CORE_NUM-1:0] ONE      = CORE_NUM'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [IDX_W-1:0]      last;
  logic [IDX_W-1:0]      cur;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] address_r;
  logic [WIDTH-1:0]      data_write_r;
  logic                  wren_r;
  logic [CORE_NUM-1:0]   grant_r;
  logic [CORE_NUM-1:0]   response_r;
  logic                  busy_r;
  logic [WIDTH-1:0]      dout_arr [CORE_NUM];
  logic [ADDR_WIDTH-1:0] addr_arr [CORE_NUM];
  logic [WIDTH-1:0]      wdat_arr [CORE_NUM];

  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      cand;
  logic                  last_beat;

  // Unpacked views of the packed per-core buses so selection uses a plain index.
  for (genvar i = 0; i < CORE_NUM; i++) begin : g_unpack
    assign addr_arr[i] = bus.address_in[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdat_arr[i] = bus.data_in[i*WIDTH +: WIDTH];
    assign bus.data_out[i*WIDTH +: WIDTH] = dout_arr[i];
  end

  assign bus.address    = address_r;
  assign bus.data_write = data_write_r;
  assign bus.wren       = wren_r;
  assign bus.grant      = grant_r;
  assign bus.response   = response_r;
  assign bus.busy       = busy_r;

  // Scan starts one past the last served core and wraps, so the most recently
  // served core has the lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= CORE_NUM; k++) begin
      cand = IDX_W'((int'(last) + k) % CORE_NUM);
      if (!found && bus.request[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign last_beat = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (found) next_state = S_ACCESS;
      S_ACCESS: if (last_beat) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last         <= IDX_LAST;
      cur          <= '0;
      cnt          <= '0;
      address_r    <= '0;
      data_write_r <= '0;
      wren_r       <= 1'b0;
      grant_r      <= '0;
      response_r   <= '0;
      busy_r       <= 1'b0;
      for (int i = 0; i < CORE_NUM; i++) begin
        dout_arr[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            address_r    <= addr_arr[winner];
            data_write_r <= wdat_arr[winner];
            wren_r       <= bus.wren_core[winner];
            grant_r      <= ONE << winner;
            cur          <= winner;
            cnt          <= '0;
            busy_r       <= 1'b1;
          end
        end
        S_ACCESS: begin
          cnt <= cnt + 1'b1;
          if (last_beat) begin
            // wren_r still holds the sampled direction on this final edge.
            if (!wren_r) begin
              dout_arr[cur] <= bus.data_read;
            end
            response_r <= ONE << cur;
            wren_r     <= 1'b0;
            last       <= cur;
          end
        end
        S_DONE: begin
          response_r <= '0;
          grant_r    <= '0;
          busy_r     <= 1'b0;
        end
        default: begin
          response_r <= '0;
          grant_r    <= '0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - self-checking bench for mem_arbiter_rr
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter_rr_if #(.WIDTH(32), .ADDR_WIDTH(32), .CORE_NUM(4)) bus4 ();
  mem_arbiter_rr_if #(.WIDTH(32), .ADDR_WIDTH(32), .CORE_NUM(8)) bus8 ();

  mem_arbiter_rr #(.WIDTH(32), .ADDR_WIDTH(32), .CORE_NUM(4), .READ_LATENCY(2)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  mem_arbiter_rr #(.WIDTH(32), .ADDR_WIDTH(32), .CORE_NUM(8), .READ_LATENCY(3)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_init(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
  endfunction

  // RAM for the 4-core instance: one register stage, so data for the address
  // presented after the grant edge is valid on the READ_LATENCY=2 final edge.
  logic [31:0] ram4 [64];
  logic [31:0] rd_q4;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram4[i] <= ram_init(i);
      rd_q4 <= '0;
    end else begin
      if (bus4.wren) ram4[bus4.address[7:2]] <= bus4.data_write;
      rd_q4 <= ram4[bus4.address[7:2]];
    end
  end
  assign bus4.data_read = rd_q4;
  assign bus8.data_read = bus8.address ^ 32'h5A5A0000;

  typedef struct {
    int          core;
    logic [31:0] data;
  } exp_t;

  exp_t        sb4 [$];
  int          q8 [$];
  logic [31:0] exp_mem [64];
  logic [31:0] dout_model [4];

  function automatic void push4(input int c, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    e.core = c;
    if (we) begin
      e.data = dout_model[c];
      exp_mem[addr[7:2]] = wd;
    end else begin
      e.data = exp_mem[addr[7:2]];
      dout_model[c] = e.data;
    end
    sb4.push_back(e);
  endfunction

  function automatic void reset_models();
    for (int i = 0; i < 64; i++) exp_mem[i] = ram_init(i);
    for (int i = 0; i < 4; i++) dout_model[i] = '0;
    sb4.delete();
  endfunction

  exp_t       m4;
  logic [3:0] prev_resp4 = '0;
  always @(negedge clk) begin
    if (!reset && bus4.response != 0) begin
      check("resp4_one_cycle", 64'(prev_resp4), 0);
      if (sb4.size() == 0) begin
        check("resp4_unexpected", 64'(bus4.response), 0);
      end else begin
        m4 = sb4.pop_front();
        check("resp4_core", 64'(bus4.response), 64'(4'(1) << m4.core));
        check("dout4", 64'(bus4.data_out[m4.core*32 +: 32]), 64'(m4.data));
      end
    end
    prev_resp4 = bus4.response;
  end

  int m8;
  always @(negedge clk) begin
    if (!reset && bus8.response != 0) begin
      if (q8.size() == 0) begin
        check("resp8_unexpected", 64'(bus8.response), 0);
      end else begin
        m8 = q8.pop_front();
        check("resp8_core", 64'(bus8.response), 64'(8'(1) << m8));
        check("dout8", 64'(bus8.data_out[m8*32 +: 32]), 64'((32'h100 * 32'(m8)) ^ 32'h5A5A0000));
      end
    end
  end

  task automatic check_zero4(input string tag);
    check({tag, "_grant"}, 64'(bus4.grant), 0);
    check({tag, "_resp"},  64'(bus4.response), 0);
    check({tag, "_busy"},  64'(bus4.busy), 0);
    check({tag, "_wren"},  64'(bus4.wren), 0);
    check({tag, "_addr"},  64'(bus4.address), 0);
    check({tag, "_wdata"}, 64'(bus4.data_write), 0);
    check({tag, "_dout"},  64'(bus4.data_out), 0);
  endtask

  // Single access by one core; inputs are scrambled after the grant to show
  // they are ignored until completion.
  task automatic access4(input int c, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bit got;
    int nw;
    @(posedge clk); #1;
    bus4.wren_core[c]           = we;
    bus4.address_in[c*32 +: 32] = addr;
    bus4.data_in[c*32 +: 32]    = wd;
    bus4.request[c]             = 1'b1;
    push4(c, we, addr, wd);
    got = 1'b0;
    nw  = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (bus4.wren) nw++;
      if (k == 1) begin
        check("acc_grant", 64'(bus4.grant), 64'(4'(1) << c));
        check("acc_busy", 64'(bus4.busy), 1);
        check("acc_addr0", 64'(bus4.address), 64'(addr));
        if (we) check("acc_wdata", 64'(bus4.data_write), 64'(wd));
        bus4.address_in[c*32 +: 32] = ~addr;
        bus4.data_in[c*32 +: 32]    = ~wd;
        bus4.wren_core[c]           = ~we;
      end
      if (k == 2) check("acc_addr1", 64'(bus4.address), 64'(addr));
      if (bus4.response != 0) begin
        got = 1'b1;
        check("acc_latency", 64'(k), 3);
        bus4.request[c] = 1'b0;
      end
    end
    check("acc_resp_seen", 64'(got), 1);
    check("acc_wren_cycles", 64'(nw), we ? 2 : 0);
    @(negedge clk);
    check("acc_idle_grant", 64'(bus4.grant), 0);
    check("acc_idle_busy", 64'(bus4.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus4.request = '0; bus4.wren_core = '0; bus4.address_in = '0; bus4.data_in = '0;
    bus8.request = '0; bus8.wren_core = '0; bus8.address_in = '0; bus8.data_in = '0;
    reset_models();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero4("por");
    reset = 1'b0;

    // All four cores request continuously: strict rotation from core 0.
    begin
      int ng = 0;
      int last_cyc = 0;
      logic [3:0] pg = '0;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
        bus4.address_in[c*32 +: 32] = 32'hC0 + 32'(4 * c);
        bus4.wren_core[c] = 1'b0;
      end
      bus4.request = 4'hF;
      for (int g = 0; g < 5; g++) push4(g % 4, 1'b0, 32'hC0 + 32'(4 * (g % 4)), '0);
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk);
        if (pg == 0 && bus4.grant != 0) begin
          check("rr_grant", 64'(bus4.grant), 64'(4'(1) << (ng % 4)));
          if (ng > 0) check("rr_period", 64'(cyc - last_cyc), 4);
          last_cyc = cyc;
          ng++;
          // Dropping the request mid-access must still complete it.
          if (ng == 5) bus4.request = '0;
        end
        pg = bus4.grant;
        if (ng == 5 && !bus4.busy) break;
      end
      check("rr_count", 64'(ng), 5);
      @(negedge clk);
      check("rr_sb_drained", 64'(sb4.size()), 0);
    end

    // Reset in the second ACCESS cycle of a write aborts it.
    begin
      bit got = 1'b0;
      bit done = 1'b0;
      logic [3:0] first_g = '0;
      @(posedge clk); #1;
      bus4.address_in[3*32 +: 32] = 32'h80;
      bus4.data_in[3*32 +: 32]    = 32'h77;
      bus4.wren_core[3]           = 1'b1;
      bus4.request[3]             = 1'b1;
      push4(3, 1'b1, 32'h80, 32'h77);
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (bus4.grant != 0) got = 1'b1;
      end
      check("abort_grant", 64'(bus4.grant), 4'b1000);
      check("abort_wren_on", 64'(bus4.wren), 1);
      @(negedge clk);
      reset = 1'b1;
      reset_models();
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check_zero4("abort");
      end
      bus4.address_in[0 +: 32] = 32'h44;
      bus4.wren_core[0]        = 1'b0;
      bus4.request             = 4'b1001;
      reset = 1'b0;
      push4(0, 1'b0, 32'h44, '0);
      push4(3, 1'b1, 32'h80, 32'h77);
      for (int k = 0; k < 30 && !done; k++) begin
        @(negedge clk);
        if (first_g == 0 && bus4.grant != 0) first_g = bus4.grant;
        if (bus4.response[0]) bus4.request[0] = 1'b0;
        if (bus4.response[3]) begin
          bus4.request[3] = 1'b0;
          done = 1'b1;
        end
      end
      check("post_rst_first", 64'(first_g), 4'b0001);
      check("post_rst_done", 64'(done), 1);
      @(negedge clk);
      check("post_rst_sb", 64'(sb4.size()), 0);
    end

    access4(2, 1'b0, 32'h40, '0);
    access4(1, 1'b1, 32'h10, 32'h55);
    access4(1, 1'b0, 32'h10, '0);

    // 8 cores, READ_LATENCY=3: after core 5, cores 7 and 3 go 7 then 3.
    begin
      bit got = 1'b0;
      bit done = 1'b0;
      logic [7:0] first_g = '0;
      @(posedge clk); #1;
      bus8.address_in[5*32 +: 32] = 32'h500;
      bus8.request[5] = 1'b1;
      q8.push_back(5);
      for (int k = 0; k < 15 && !got; k++) begin
        @(negedge clk);
        if (bus8.response != 0) begin
          got = 1'b1;
          check("lat8", 64'(k), 4);
          bus8.request[5] = 1'b0;
        end
      end
      check("c5_served", 64'(got), 1);
      @(posedge clk); #1;
      bus8.address_in[7*32 +: 32] = 32'h700;
      bus8.address_in[3*32 +: 32] = 32'h300;
      bus8.request[7] = 1'b1;
      bus8.request[3] = 1'b1;
      q8.push_back(7);
      q8.push_back(3);
      for (int k = 0; k < 30 && !done; k++) begin
        @(negedge clk);
        if (first_g == 0 && bus8.grant != 0) first_g = bus8.grant;
        if (bus8.response[7]) bus8.request[7] = 1'b0;
        if (bus8.response[3]) begin
          bus8.request[3] = 1'b0;
          done = 1'b1;
        end
      end
      check("c8_first", 64'(first_g), 8'h80);
      check("c8_done", 64'(done), 1);
      @(negedge clk);
      check("c8_q_drained", 64'(q8.size()), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
